// File: rtl/cc_rst_seq_if.sv
// Signal bundle between the system-config register block, the reset sequencer
// and the core it controls.
interface cc_rst_seq_if;
  logic        cfg_rst;
  logic [31:0] cfg_boot;
  logic        halt_ack;
  logic        core_rst;
  logic [31:0] boot_addr;
  logic        halt_req;
  logic [2:0]  state;
  logic        timeout;
  logic [7:0]  rst_count;

  modport master (
    output cfg_rst, cfg_boot, halt_ack,
    input  core_rst, boot_addr, halt_req, state, timeout, rst_count
  );

  modport slave (
    input  cfg_rst, cfg_boot, halt_ack,
    output core_rst, boot_addr, halt_req, state, timeout, rst_count
  );
endinterface

// File: rtl/cc_rst_seq.sv
// Per-core reset sequencer: enforces a minimum reset width, a boot-address setup
// window before release, and a bounded bus drain before reset is re-asserted.
module cc_rst_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int SETUP_CYCLES  = 4,
  parameter int DRAIN_TIMEOUT = 256
) (
  input logic         PCLK,
  input logic         PRESET,
  cc_rst_seq_if.slave bus
);

  localparam int MAX_RS  = (RST_CYCLES > SETUP_CYCLES) ? RST_CYCLES : SETUP_CYCLES;
  localparam int MAX_ALL = (MAX_RS > DRAIN_TIMEOUT) ? MAX_RS : DRAIN_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;

  localparam logic [CNT_W-1:0] RST_SAT    = CNT_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_HOLD  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3
  } state_e;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [31:0]      boot_q,     boot_d;
  logic             core_rst_q, core_rst_d;
  logic             halt_req_q, halt_req_d;
  logic             timeout_q,  timeout_d;
  logic [7:0]       rst_cnt_q,  rst_cnt_d;

  // Next-state, counter and status decode; core_rst/halt_req follow the next state
  // so they change on the same edge as the state register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    boot_d    = boot_q;
    timeout_d = timeout_q;
    rst_cnt_d = rst_cnt_q;

    case (state_q)
      ST_HOLD: begin
        if ((cnt_q >= RST_LAST) && !bus.cfg_rst) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          boot_d  = bus.cfg_boot & 32'hFFFF_FFFC;
        end else if (cnt_q < RST_SAT) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_SETUP: begin
        if (bus.cfg_rst) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q >= SETUP_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (bus.cfg_rst) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
          if (rst_cnt_q != 8'hFF) begin
            rst_cnt_d = rst_cnt_q + 8'd1;
          end else begin
            rst_cnt_d = rst_cnt_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // An ack on the final drain cycle still wins over the timeout.
        if (bus.halt_ack) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q >= DRAIN_LAST) begin
          state_d   = ST_HOLD;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase

    core_rst_d = !((state_d == ST_RUN) || (state_d == ST_DRAIN));
    halt_req_d = (state_d == ST_DRAIN);
  end

  // State, counter and output registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      boot_q     <= 32'd0;
      core_rst_q <= 1'b1;
      halt_req_q <= 1'b0;
      timeout_q  <= 1'b0;
      rst_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      boot_q     <= boot_d;
      core_rst_q <= core_rst_d;
      halt_req_q <= halt_req_d;
      timeout_q  <= timeout_d;
      rst_cnt_q  <= rst_cnt_d;
    end
  end

  assign bus.core_rst  = core_rst_q;
  assign bus.boot_addr = boot_q;
  assign bus.halt_req  = halt_req_q;
  assign bus.state     = state_q;
  assign bus.timeout   = timeout_q;
  assign bus.rst_count = rst_cnt_q;

endmodule

// File: tb/tb_cc_rst_seq.sv
// Scoreboard bench for cc_rst_seq: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cc_rst_seq;

  localparam int K_CORE  = 0;
  localparam int K_BOOT  = 1;
  localparam int K_HALT  = 2;
  localparam int K_STATE = 3;
  localparam int K_TMO   = 4;
  localparam int K_RCNT  = 5;

  typedef struct {
    int          tgt;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic flush = 1'b0;
  exp_t sb[$];

  cc_rst_seq_if bus();

  cc_rst_seq dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      K_CORE:  return "core_rst";
      K_BOOT:  return "boot_addr";
      K_HALT:  return "halt_req";
      K_STATE: return "state";
      K_TMO:   return "timeout";
      K_RCNT:  return "rst_count";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] actual(int k);
    case (k)
      K_CORE:  return {31'd0, bus.core_rst};
      K_BOOT:  return bus.boot_addr;
      K_HALT:  return {31'd0, bus.halt_req};
      K_STATE: return {29'd0, bus.state};
      K_TMO:   return {31'd0, bus.timeout};
      K_RCNT:  return {24'd0, bus.rst_count};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] got;
    while (sb.size() > 0 && (flush || sb[0].tgt <= cyc)) begin
      e   = sb.pop_front();
      got = actual(e.kind);
      n_cmp++;
      if (flush) begin
        n_err++;
        $display("FAIL %s never checked (due cyc=%0d) exp=%h", kname(e.kind), e.tgt, e.val);
      end else if (e.tgt != cyc || got !== e.val) begin
        n_err++;
        $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h", kname(e.kind), cyc, e.tgt, got, e.val);
      end
    end
  end

  task automatic chk(input int tgt, input int kind, input logic [31:0] val);
    exp_t e;
    int   idx;
    e.tgt  = tgt;
    e.kind = kind;
    e.val  = val;
    idx    = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].tgt > tgt) begin
        idx = i;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int sat;

    rst          = 1'b1;
    bus.cfg_rst  = 1'b0;
    bus.cfg_boot = 32'h0001_0000;
    bus.halt_ack = 1'b0;

    // Reset values while PRESET is held.
    tick(3);
    chk(cyc + 1, K_CORE, 32'd1);
    chk(cyc + 1, K_BOOT, 32'd0);
    chk(cyc + 1, K_HALT, 32'd0);
    chk(cyc + 1, K_STATE, 32'd0);
    chk(cyc + 1, K_TMO, 32'd0);
    chk(cyc + 1, K_RCNT, 32'd0);
    tick(1);

    // Power-on: 16 HOLD + 4 SETUP cycles, core_rst falls on cycle 20.
    rst = 1'b0;
    b   = cyc;
    chk(b + 15, K_STATE, 32'd0);
    chk(b + 15, K_BOOT, 32'd0);
    chk(b + 16, K_STATE, 32'd1);
    chk(b + 16, K_BOOT, 32'h0001_0000);
    chk(b + 19, K_CORE, 32'd1);
    chk(b + 19, K_STATE, 32'd1);
    chk(b + 20, K_CORE, 32'd0);
    chk(b + 20, K_STATE, 32'd2);
    goto(b + 22);

    // Software reset with ack in the 4th DRAIN cycle; cfg_rst drops mid-drain.
    b = cyc;
    bus.cfg_rst = 1'b1;
    chk(b + 1, K_STATE, 32'd3);
    chk(b + 1, K_HALT, 32'd1);
    chk(b + 1, K_CORE, 32'd0);
    chk(b + 1, K_RCNT, 32'd1);
    chk(b + 4, K_STATE, 32'd3);
    chk(b + 4, K_HALT, 32'd1);
    chk(b + 5, K_STATE, 32'd0);
    chk(b + 5, K_CORE, 32'd1);
    chk(b + 5, K_HALT, 32'd0);
    chk(b + 5, K_TMO, 32'd0);
    chk(b + 5, K_RCNT, 32'd1);
    chk(b + 20, K_STATE, 32'd0);
    chk(b + 21, K_STATE, 32'd1);
    chk(b + 21, K_BOOT, 32'h8000_0000);
    chk(b + 24, K_CORE, 32'd1);
    chk(b + 25, K_CORE, 32'd0);
    chk(b + 25, K_STATE, 32'd2);
    goto(b + 1);
    bus.cfg_rst  = 1'b0;
    bus.cfg_boot = 32'h8000_0003;
    goto(b + 4);
    bus.halt_ack = 1'b1;
    goto(b + 5);
    bus.halt_ack = 1'b0;

    // Boot address stays frozen while cfg_boot churns; halt_ack ignored in RUN.
    for (int i = 21; i <= 30; i++) begin
      goto(b + i);
      bus.cfg_boot = 32'hDEAD_0000 + 32'(i);
      bus.halt_ack = (i >= 25) ? i[0] : 1'b0;
      chk(b + i + 1, K_BOOT, 32'h8000_0000);
    end
    chk(b + 31, K_STATE, 32'd2);
    chk(b + 31, K_HALT, 32'd0);
    goto(b + 31);
    bus.halt_ack = 1'b0;
    bus.cfg_boot = 32'h1234_567B;

    // Drain timeout: halt_req high exactly 256 cycles, then sticky timeout.
    b = cyc;
    bus.cfg_rst = 1'b1;
    chk(b + 1, K_STATE, 32'd3);
    chk(b + 1, K_HALT, 32'd1);
    chk(b + 1, K_RCNT, 32'd2);
    chk(b + 256, K_STATE, 32'd3);
    chk(b + 256, K_HALT, 32'd1);
    chk(b + 256, K_TMO, 32'd0);
    chk(b + 257, K_STATE, 32'd0);
    chk(b + 257, K_HALT, 32'd0);
    chk(b + 257, K_CORE, 32'd1);
    chk(b + 257, K_TMO, 32'd1);
    chk(b + 276, K_CORE, 32'd1);
    chk(b + 277, K_CORE, 32'd0);
    chk(b + 277, K_STATE, 32'd2);
    goto(b + 1);
    bus.cfg_rst = 1'b0;
    goto(b + 278);

    // Acked reset keeps timeout sticky, then a 1-cycle cfg_rst pulse in SETUP.
    b = cyc;
    bus.cfg_rst = 1'b1;
    chk(b + 1, K_STATE, 32'd3);
    chk(b + 1, K_RCNT, 32'd3);
    chk(b + 2, K_STATE, 32'd0);
    chk(b + 2, K_TMO, 32'd1);
    chk(b + 18, K_STATE, 32'd1);
    chk(b + 18, K_BOOT, 32'h1234_5678);
    chk(b + 19, K_STATE, 32'd1);
    chk(b + 20, K_STATE, 32'd0);
    chk(b + 35, K_STATE, 32'd0);
    chk(b + 36, K_STATE, 32'd1);
    chk(b + 40, K_STATE, 32'd2);
    chk(b + 40, K_TMO, 32'd1);
    for (int i = 2; i <= 40; i++) chk(b + i, K_CORE, (i < 40) ? 32'd1 : 32'd0);
    goto(b + 1);
    bus.cfg_rst  = 1'b0;
    bus.halt_ack = 1'b1;
    goto(b + 2);
    bus.halt_ack = 1'b0;
    goto(b + 19);
    bus.cfg_rst = 1'b1;
    goto(b + 20);
    bus.cfg_rst = 1'b0;
    goto(b + 41);

    // Asynchronous PRESET in the middle of DRAIN.
    b = cyc;
    bus.cfg_rst = 1'b1;
    chk(b + 5, K_STATE, 32'd3);
    chk(b + 5, K_HALT, 32'd1);
    chk(b + 5, K_RCNT, 32'd4);
    goto(b + 1);
    bus.cfg_rst = 1'b0;
    goto(b + 5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk(cyc, K_CORE, 32'd1);
    chk(cyc, K_HALT, 32'd0);
    chk(cyc, K_STATE, 32'd0);
    chk(cyc, K_RCNT, 32'd0);
    chk(cyc, K_TMO, 32'd0);
    chk(cyc, K_BOOT, 32'd0);
    chk(b + 7, K_CORE, 32'd1);
    goto(b + 8);
    rst = 1'b0;
    b   = cyc;
    chk(b + 19, K_CORE, 32'd1);
    chk(b + 20, K_CORE, 32'd0);
    chk(b + 20, K_STATE, 32'd2);
    chk(b + 20, K_BOOT, 32'h1234_5678);
    chk(b + 20, K_RCNT, 32'd0);
    goto(b + 21);

    // 300 quick reset cycles: rst_count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      sat = (i + 1 > 255) ? 255 : i + 1;
      bus.cfg_rst = 1'b1;
      chk(cyc + 1, K_STATE, 32'd3);
      chk(cyc + 1, K_RCNT, 32'(sat));
      tick(1);
      bus.cfg_rst  = 1'b0;
      bus.halt_ack = 1'b1;
      tick(1);
      bus.halt_ack = 1'b0;
      tick(20);
    end
    chk(cyc + 1, K_RCNT, 32'd255);
    chk(cyc + 1, K_STATE, 32'd2);
    tick(3);

    flush = 1'b1;
    tick(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
